// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
// Round-robin arbiter that merges N valid/ready senders onto one registered
// output stage. The current owner may keep the grant for up to BURST
// consecutive beats while it stays valid; each beat is tagged with its source
// index on out_id.
module handshake_rr_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int IDW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IDW-1:0]  out_id
);

    localparam int             CW        = $clog2(BURST + 1);
    localparam logic [CW-1:0]  BURST_MAX = CW'(BURST);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    logic            out_valid_reg, out_valid_next;
    logic [DW-1:0]   out_data_reg,  out_data_next;
    logic [IDW-1:0]  out_id_reg,    out_id_next;
    logic [IDW-1:0]  owner_reg,     owner_next;
    logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;

    logic [DW-1:0]   in_data_arr [N];
    logic            load;
    logic            any_valid;
    logic            owner_keep;
    logic            search_found;
    logic [IDW-1:0]  search_id;
    logic [IDW-1:0]  cand_id;
    logic [IDW-1:0]  sel_id;

    // Unpack the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign in_data_arr[gi] = in_data[gi*DW +: DW];
        end
    endgenerate

    // The output register can take a new beat when empty or draining this cycle.
    assign load      = !out_valid_reg || out_ready;
    assign any_valid = |in_valid;

    // A zero burst count means nobody holds the grant (after reset or a release),
    // so the owner only gets sticky priority while it is mid-burst.
    assign owner_keep = in_valid[owner_reg] && (burst_cnt_reg != '0) &&
                        (burst_cnt_reg < BURST_MAX);

    // Rotating search starting just after the owner; the owner itself comes last.
    always_comb begin
        search_found = 1'b0;
        search_id    = owner_reg;
        cand_id      = owner_reg;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = int'(owner_reg) + k;
            if (c >= N) begin
                c = c - N;
            end
            cand_id = IDW'(c);
            if (!search_found && in_valid[cand_id]) begin
                search_found = 1'b1;
                search_id    = cand_id;
            end
        end
    end

    assign sel_id = owner_keep ? owner_reg : search_id;

    // Grant is one-hot on the selected requester, only in a load slot with demand.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = load && any_valid && (sel_id == IDW'(gi));
        end
    endgenerate

    // Next-state for the output stage, owner and burst counter.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_id_next    = out_id_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        if (load) begin
            if (any_valid) begin
                out_valid_next = 1'b1;
                out_data_next  = in_data_arr[sel_id];
                out_id_next    = sel_id;
                if (sel_id == owner_reg) begin
                    // An exhausted owner that wins again (sole requester) starts a fresh burst.
                    if (burst_cnt_reg >= BURST_MAX) begin
                        burst_cnt_next = CW'(1);
                    end else begin
                        burst_cnt_next = burst_cnt_reg + CW'(1);
                    end
                end else begin
                    owner_next     = sel_id;
                    burst_cnt_next = CW'(1);
                end
            end else begin
                // Nothing to send: empty the stage and treat the owner as released.
                out_valid_next = 1'b0;
                out_data_next  = '0;
                burst_cnt_next = '0;
            end
        end
    end

    // State registers; reset drops any held beat at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
            owner_reg     <= LAST_ID;
            burst_cnt_reg <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_id_reg    <= out_id_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: one instance with BURST=4 and one with
// BURST=1 share the stimulus. Expected beats are queued when stimulus is
// driven and compared as each beat leaves the output register.
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    logic            out_ready = 1'b0;

    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;

    logic [N-1:0]    in_ready_rr;
    logic            out_valid_rr;
    logic [DW-1:0]   out_data_rr;
    logic [1:0]      out_id_rr;

    int   checks = 0;
    int   errors = 0;
    bit   sb_rr  = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    handshake_rr_arbiter #(.N(N), .DW(DW), .BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    handshake_rr_arbiter #(.N(N), .DW(DW), .BURST(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready_rr),
        .out_valid (out_valid_rr),
        .out_ready (out_ready),
        .out_data  (out_data_rr),
        .out_id    (out_id_rr)
    );

    // Requester i always offers 0x11*(i+1).
    function automatic exp_t exp_of(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = 8'((id + 1) * 17);
        return e;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    // One clock: drive new inputs 1 time unit after the edge, settle, then
    // pop and compare a beat that will depart on the coming edge.
    task automatic sb_cycle(input logic [N-1:0] v, input logic r);
        logic       ov;
        logic [7:0] od;
        logic [1:0] oi;
        exp_t       e;
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        #1;
        ov = sb_rr ? out_valid_rr : out_valid;
        od = sb_rr ? out_data_rr  : out_data;
        oi = sb_rr ? out_id_rr    : out_id;
        if (ov && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_beat got id=%0d data=%h, expected no beat", oi, od);
            end else begin
                e = sb_q.pop_front();
                if (oi !== e.id || od !== e.data) begin
                    errors++;
                    $display("FAIL sb_beat got id=%0d data=%h, expected id=%0d data=%h",
                             oi, od, e.id, e.data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_id, in_ready} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h id=%0d rdy=%b, expected all 0",
                     out_valid, out_data, out_id, in_ready);
        end
        checks++;
        if ({out_valid_rr, out_data_rr, out_id_rr, in_ready_rr} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state_rr got v=%b d=%h id=%0d rdy=%b, expected all 0",
                     out_valid_rr, out_data_rr, out_id_rr, in_ready_rr);
        end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        sb_q.push_back(exp_of(0));
        sb_cycle(4'b0001, 1'b1);
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_in_ready got %b, expected 0001", in_ready);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL single_out got v=%b d=%h id=%0d, expected v=1 d=11 id=0",
                     out_valid, out_data, out_id);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL single_idle got v=%b d=%h id=%0d, expected v=0 d=00 id=0",
                     out_valid, out_data, out_id);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("test_single done");
    endtask

    task automatic test_rr_pure();
        sb_rr = 1'b1;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back(exp_of(i % 4));
            sb_cycle(4'b1111, 1'b1);
            if (i > 0) begin
                checks++;
                if (out_valid_rr !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_no_bubble cycle %0d got out_valid=%b, expected 1", i, out_valid_rr);
                end
            end
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain got %0d pending, expected 0", sb_q.size());
        end
        sb_rr = 1'b0;
        $display("test_rr_pure done");
    endtask

    task automatic test_burst();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back(exp_of(i / 4));
            sb_cycle(4'b1111, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            sb_q.push_back(exp_of(2));
            sb_cycle(4'b0100, 1'b1);
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL burst_solo_ready cycle %0d got %b, expected 0100", i, in_ready);
            end
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL burst_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("test_burst done");
    endtask

    task automatic test_backpressure();
        apply_reset();
        sb_q.push_back(exp_of(0));
        sb_cycle(4'b0011, 1'b1);
        sb_cycle(4'b0011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sb_cycle(4'b0011, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_id !== 2'd0 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold cycle %0d got v=%b d=%h id=%0d rdy=%b, expected v=1 d=11 id=0 rdy=0000",
                         i, out_valid, out_data, out_id, in_ready);
            end
        end
        sb_q.push_back(exp_of(1));
        sb_cycle(4'b0010, 1'b1);
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL release_ready got %b, expected 0010", in_ready);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL release_no_bubble got v=%b id=%0d, expected v=1 id=1", out_valid, out_id);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_drain got v=%b pending=%0d, expected v=0 pending=0",
                     out_valid, sb_q.size());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_owner_release();
        int seq [9] = '{3, 3, 3, 3, 0, 0, 0, 0, 3};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(exp_of(2));
            sb_cycle(4'b0100, 1'b1);
        end
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(exp_of(seq[i]));
            sb_cycle(4'b1001, 1'b1);
            if (i == 0) begin
                checks++;
                if (in_ready !== 4'b1000) begin
                    errors++;
                    $display("FAIL release_wrap got in_ready=%b, expected 1000", in_ready);
                end
            end
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL owner_release_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("test_owner_release done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        sb_q.push_back(exp_of(0));
        sb_cycle(4'b1111, 1'b1);
        sb_q.push_back(exp_of(0));
        sb_cycle(4'b1111, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b, expected 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h id=%0d, expected v=0 d=00 id=0",
                     out_valid, out_data, out_id);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        sb_q.push_back(exp_of(1));
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_ready got %b, expected 0010", in_ready);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_first got v=%b id=%0d, expected v=1 id=1", out_valid, out_id);
        end
        sb_cycle(4'b0000, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL async_reset_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_pure();
        test_burst();
        test_backpressure();
        test_owner_release();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
